// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int DIV_DW = 32;
  localparam int DIV_CW = $clog2(DIV_DW);

  // Quotient reported for a zero divisor, in both signed and unsigned modes.
  localparam logic [DIV_DW-1:0] DIV_ZERO_QUOT = {DIV_DW{1'b1}};

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift {rem, dividend} left, trial-subtract the
// divisor and keep the difference only when it does not go negative.
module div_iter_step
  import div_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic [DW-1:0] i_rem,
  input  logic [DW-1:0] i_dvd,
  input  logic [DW-1:0] i_dvs,
  output logic [DW-1:0] o_rem,
  output logic [DW-1:0] o_dvd,
  output logic          o_bit
);

  logic [DW:0] w_rem_sh;
  logic [DW:0] w_trial;

  // DW+1 bits suffice: rem < divisor, so a non-negative trial never sets bit DW.
  assign w_rem_sh = {i_rem, i_dvd[DW-1]};
  assign w_trial  = w_rem_sh - {1'b0, i_dvs};
  assign o_bit    = ~w_trial[DW];
  assign o_rem    = o_bit ? w_trial[DW-1:0] : w_rem_sh[DW-1:0];
  assign o_dvd    = {i_dvd[DW-2:0], o_bit};

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit for the execute stage: holds the pipeline via
// o_stall_req while iterating and pulses o_ready with the {HI, LO} result.
module div_unit
  import div_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_signed_div,
  input  logic            i_annul,
  input  logic [DW-1:0]   i_opa,
  input  logic [DW-1:0]   i_opb,
  output logic [2*DW-1:0] o_result,
  output logic            o_ready,
  output logic            o_stall_req
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  div_state_e      r_state;
  div_state_e      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_rem;
  logic [DW-1:0]   r_dvd;
  logic [DW-1:0]   r_dvs;
  logic            r_qsign;
  logic            r_rsign;
  logic [2*DW-1:0] r_result;
  logic            r_ready;

  logic [DW-1:0]   w_rem_nxt;
  logic [DW-1:0]   w_dvd_nxt;
  logic            w_bit;
  logic            w_launch;
  logic            w_opb_zero;
  logic            w_last;
  logic [DW-1:0]   w_quot_fin;
  logic [DW-1:0]   w_rem_fin;

  function automatic logic [DW-1:0] f_mag(input logic [DW-1:0] v, input logic sd);
    return (sd && v[DW-1]) ? -v : v;
  endfunction

  div_iter_step #(.DW(DW)) u_step (
    .i_rem (r_rem),
    .i_dvd (r_dvd),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_dvd (w_dvd_nxt),
    .o_bit (w_bit)
  );

  assign w_launch   = (r_state == S_IDLE) && i_start && !i_annul;
  assign w_opb_zero = (i_opb == {DW{1'b0}});
  assign w_last     = (r_cnt == CW'(DW - 1));
  assign w_quot_fin = r_qsign ? -w_dvd_nxt : w_dvd_nxt;
  assign w_rem_fin  = r_rsign ? -w_rem_nxt : w_rem_nxt;

  assign o_stall_req = w_launch || (r_state == S_BUSY) || (r_state == S_ZERO);
  assign o_result    = r_result;
  assign o_ready     = r_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Annul pulls any active state back to IDLE ahead of every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_state_nxt = w_opb_zero ? S_ZERO : S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ZERO: begin
        w_state_nxt = i_annul ? S_IDLE : S_DONE;
      end
      S_BUSY: begin
        if (i_annul) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            // A zero divisor keeps the raw dividend for the HI result.
            r_dvd   <= w_opb_zero ? i_opa : f_mag(i_opa, i_signed_div);
            r_dvs   <= f_mag(i_opb, i_signed_div);
            r_qsign <= i_signed_div & (i_opa[DW-1] ^ i_opb[DW-1]);
            r_rsign <= i_signed_div & i_opa[DW-1];
          end
        end
        S_ZERO: begin
          if (!i_annul) begin
            r_result <= {r_dvd, DW'(DIV_ZERO_QUOT)};
            r_ready  <= 1'b1;
          end
        end
        S_BUSY: begin
          if (!i_annul) begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_dvd_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_result <= {w_rem_fin, w_quot_fin};
              r_ready  <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, annul/reset sequences and
// randomized operands against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_signed_div, i_annul;
  logic [31:0] i_opa, i_opb;
  logic [63:0] o_result;
  logic        o_ready, o_stall_req;

  int          tests = 0;
  int          failed = 0;
  logic [63:0] exp_hold;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] expv;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  div_unit #(.DW(32)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_signed_div (i_signed_div),
    .i_annul      (i_annul),
    .i_opa        (i_opa),
    .i_opb        (i_opb),
    .o_result     (o_result),
    .o_ready      (o_ready),
    .o_stall_req  (o_stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference: plain integer division with C-style truncation toward zero.
  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sd) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expv, input int lat, input int annul_cyc,
                         input int win, input bit stray, input string nm);
    int          nrdy, rdy_cyc, stall_bad;
    logic [63:0] got;
    logic        exp_st;
    nrdy = 0; rdy_cyc = -1; stall_bad = 0; got = 64'd0;
    @(negedge clk);
    i_start = 1'b1; i_signed_div = sd; i_opa = a; i_opb = b; i_annul = 1'b0;
    #1;
    if (o_stall_req !== 1'b1) stall_bad++;
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      if (stray && (annul_cyc == 0) && (c <= lat)) begin
        i_start = 1'($urandom_range(0, 1));
        i_opa   = $urandom;
        i_opb   = $urandom;
      end else begin
        i_start = 1'b0;
      end
      i_annul = (c == annul_cyc);
      #1;
      if (o_ready === 1'b1) begin
        nrdy++;
        if (rdy_cyc < 0) begin
          rdy_cyc = c;
          got = o_result;
        end
      end
      exp_st = (annul_cyc > 0) ? (c <= annul_cyc) : (c < lat);
      if (o_stall_req !== exp_st) stall_bad++;
    end
    i_start = 1'b0;
    i_annul = 1'b0;
    chk({nm, "_stall"}, 64'(stall_bad), 64'd0);
    if (annul_cyc > 0) begin
      chk({nm, "_no_ready"}, 64'(nrdy), 64'd0);
      chk({nm, "_held"}, o_result, exp_hold);
    end else begin
      chk({nm, "_ready_cnt"}, 64'(nrdy), 64'd1);
      chk({nm, "_ready_cyc"}, 64'(rdy_cyc), 64'(lat));
      chk({nm, "_result"}, got, expv);
      chk({nm, "_held"}, o_result, expv);
      exp_hold = expv;
    end
  endtask

  initial begin
    logic        sd;
    logic [31:0] a, b;
    logic [63:0] e;
    int          lat, nrdy;

    i_reset = 1'b1; i_start = 1'b0; i_signed_div = 1'b0; i_annul = 1'b0;
    i_opa = 32'd0; i_opb = 32'd0; exp_hold = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_result", o_result, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd0);
    chk("rst_stall", {63'd0, o_stall_req}, 64'd0);
    i_reset = 1'b0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33};
    vecs[3] = '{1'b0, 32'hFFFF_FFF9,  32'd2,        64'h00000001_7FFFFFFC, 33};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 64'h00000000_80000000, 33};
    vecs[5] = '{1'b0, 32'h0000_1234,  32'd0,        64'h00001234_FFFFFFFF, 2};
    vecs[6] = '{1'b1, 32'hFFFF_FFF9,  32'd0,        64'hFFFFFFF9_FFFFFFFF, 2};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        64'h00000000_FFFFFFFF, 33};
    vecs[8] = '{1'b0, 32'd5,          32'hFFFF_FFFF, 64'h00000005_00000000, 33};
    vecs[9] = '{1'b1, 32'h8000_0000,  32'd1,        64'h00000000_80000000, 33};

    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].expv, vecs[i].lat, 0,
              vecs[i].lat + 3, (i % 2) == 1, $sformatf("vec%0d", i));
    end

    // Annul at cycle 10, then a fresh divide started at cycle 12.
    run_div(1'b0, 32'd100, 32'd7, 64'd0, 33, 10, 11, 1'b0, "annul");
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0, 36, 1'b0, "after_annul");

    // Reset in cycle 20 of a divide: outputs clear next cycle, no ready ever.
    nrdy = 0;
    @(negedge clk);
    i_start = 1'b1; i_signed_div = 1'b0; i_opa = 32'd100; i_opb = 32'd7;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      i_start = (c < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_reset = (c == 20);
      #1;
      if (o_ready === 1'b1) nrdy++;
    end
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    chk("midrst_result", o_result, 64'd0);
    chk("midrst_ready", {63'd0, o_ready}, 64'd0);
    chk("midrst_stall", {63'd0, o_stall_req}, 64'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (o_ready === 1'b1) nrdy++;
    end
    chk("midrst_no_ready", 64'(nrdy), 64'd0);
    exp_hold = 64'd0;

    for (int i = 0; i < 60; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = $urandom_range(0, 15);
        1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = b >> $urandom_range(0, 31);
        default: begin end
      endcase
      e   = ref_div(sd, a, b);
      lat = (b == 32'd0) ? 2 : 33;
      run_div(sd, a, b, e, lat, 0, lat, 1'b1, $sformatf("rand%0d", i));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
